// File: rtl/intr_priority_ctrl.sv
// Six-source fixed-priority interrupt controller with an IDLE/REQ/HOLD request handshake.
// Optional feature: define INTR_NEST_EN to let higher-priority sources preempt in-service ones.
module intr_priority_ctrl #(
    parameter int EDGE_TRIG = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [5:0] INTR_REQ,
    input  logic       MASK_WE,
    input  logic [5:0] MASK_WDATA,
    input  logic       INTA,
    input  logic       uret,
    output logic       INTR,
    output logic [2:0] INTR_ID,
    output logic [5:0] PENDING,
    output logic [5:0] IN_SERVICE
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t     state;
    logic [5:0] pending;
    logic [5:0] in_service;
    logic [5:0] mask;
    logic [5:0] req_prev;
    logic [5:0] isr_top;
    logic [5:0] nest_ok;
    logic [5:0] eligible;
    logic [5:0] ack_vec;
    logic [5:0] pending_nxt;
    logic [5:0] in_service_nxt;
    logic [2:0] cand_id;
    logic       ack;

    // Bit 0 is source 1, the highest priority; returns 1..6, or 0 when nothing is set.
    function automatic logic [2:0] first_id(input logic [5:0] v);
        logic [2:0] id;
        id = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (v[i]) id = 3'(i + 1);
        end
        return id;
    endfunction

    assign isr_top = in_service & (~in_service + 6'd1);

`ifdef INTR_NEST_EN
    // Sources strictly above the highest-priority in-service one; all ones when nothing is in service.
    assign nest_ok = isr_top - 6'd1;
`else
    assign nest_ok = (in_service == 6'd0) ? 6'h3f : 6'h00;
`endif

    assign eligible = pending & ~mask & ~in_service & nest_ok;
    assign cand_id  = first_id(eligible);
    assign ack      = (state == REQ) && INTA;

    always_comb begin
        // NOTE: give every combinationally assigned signal a default first so no path infers a latch.
        ack_vec = '0;
        for (int i = 0; i < 6; i++) begin
            ack_vec[i] = ack && (INTR_ID == 3'(i + 1));
        end
    end

    // Return clears using the pre-edge in_service; a same-cycle acknowledge is OR'd in so it wins.
    assign in_service_nxt = (in_service & ~(uret ? isr_top : 6'd0)) | ack_vec;

    generate
        if (EDGE_TRIG != 0) begin : g_edge
            assign pending_nxt = (pending & ~ack_vec) | (INTR_REQ & ~req_prev);
        end else begin : g_level
            assign pending_nxt = INTR_REQ;
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pending    <= '0;
            in_service <= '0;
            mask       <= '0;
            req_prev   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            pending    <= pending_nxt;
            in_service <= in_service_nxt;
            req_prev   <= INTR_REQ;
            if (MASK_WE) mask <= MASK_WDATA;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            INTR    <= 1'b0;
            INTR_ID <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cand_id != 3'd0) begin
                        state   <= REQ;
                        INTR    <= 1'b1;
                        INTR_ID <= cand_id;
                    end
                end
                REQ: begin
                    if (INTA) begin
                        state   <= HOLD;
                        INTR    <= 1'b0;
                        INTR_ID <= 3'd0;
                    end else if (cand_id == 3'd0) begin
                        state   <= IDLE;
                        INTR    <= 1'b0;
                        INTR_ID <= 3'd0;
                    end else begin
                        INTR_ID <= cand_id;
                    end
                end
                HOLD: begin
                    state   <= IDLE;
                    INTR    <= 1'b0;
                    INTR_ID <= 3'd0;
                end
                default: begin
                    state   <= IDLE;
                    INTR    <= 1'b0;
                    INTR_ID <= 3'd0;
                end
            endcase
        end
    end

    assign PENDING    = pending;
    assign IN_SERVICE = in_service;

endmodule
